// File: rtl/serial_sched.sv
// serial_sched: round-robin arbiter feeding a word serializer (LSB first).
// A granted word is shifted out one bit per i_stp strobe; one IDLE cycle
// separates consecutive words. Optional macro SERIAL_SCHED_PARITY_EN appends
// an even-parity bit (PAR state) after the data bits.
module serial_sched #(
  parameter int p_width = 8,
  parameter int p_ports = 4,
  localparam int SW = (p_ports > 1) ? $clog2(p_ports) : 1,
  localparam int CW = (p_width > 1) ? $clog2(p_width) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [p_ports-1:0]         i_req,
  input  logic [p_ports*p_width-1:0] i_data,
  input  logic                       i_stp,
  output logic [p_ports-1:0]         o_ack,
  output logic                       o_val,
  output logic                       o_sof,
  output logic                       o_last,
  output logic                       o_busy,
  output logic [SW-1:0]              o_src
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SERIAL_SCHED_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd2;
`endif

  logic [1:0]         state_q, state_d;
  logic [SW-1:0]      ptr_q, ptr_d;
  logic [SW-1:0]      src_q, src_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [p_width-1:0] sh_q, sh_d;
  logic [p_ports-1:0] ack_q, ack_d;
`ifdef SERIAL_SCHED_PARITY_EN
  logic               par_q, par_d;
`endif

  logic [p_width-1:0] words [p_ports];
  logic               gnt_vld;
  logic [SW-1:0]      gnt_idx;
  logic               at_last;

  for (genvar k = 0; k < p_ports; k++) begin : g_words
    assign words[k] = i_data[k*p_width +: p_width];
  end

  assign at_last = (cnt_q == CW'(p_width - 1));

  // Round-robin pick: first requester at or above the pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < p_ports; i++) begin
      int j;
      logic [SW-1:0] jx;
      j = int'(ptr_q) + i;
      if (j >= p_ports) j = j - p_ports;
      jx = SW'(j);
      if (!gnt_vld && i_req[jx]) begin
        gnt_vld = 1'b1;
        gnt_idx = jx;
      end
    end
  end

  // Next-state: arbitrate only in IDLE, shift on each strobe otherwise.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ack_d   = '0;
`ifdef SERIAL_SCHED_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          sh_d           = words[gnt_idx];
          cnt_d          = '0;
          src_d          = gnt_idx;
          ptr_d          = (gnt_idx == SW'(p_ports - 1)) ? '0 : gnt_idx + SW'(1);
          ack_d[gnt_idx] = 1'b1;
          state_d        = S_SHIFT;
`ifdef SERIAL_SCHED_PARITY_EN
          par_d          = ^words[gnt_idx];
`endif
        end
      end
      S_SHIFT: begin
        if (i_stp) begin
          sh_d = sh_q >> 1;
          if (at_last) begin
            // counter restarts so it never wraps past p_width-1
            cnt_d = '0;
`ifdef SERIAL_SCHED_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef SERIAL_SCHED_PARITY_EN
      S_PAR: begin
        if (i_stp) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset wins over request and strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      ack_q   <= '0;
`ifdef SERIAL_SCHED_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ack_q   <= ack_d;
`ifdef SERIAL_SCHED_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Output decode from state; everything is quiet in IDLE.
  always_comb begin
    o_val  = 1'b0;
    o_sof  = 1'b0;
    o_last = 1'b0;
    o_busy = 1'b0;
    case (state_q)
      S_SHIFT: begin
        o_val  = sh_q[0];
        o_sof  = (cnt_q == '0);
        o_busy = 1'b1;
`ifndef SERIAL_SCHED_PARITY_EN
        o_last = at_last;
`endif
      end
`ifdef SERIAL_SCHED_PARITY_EN
      S_PAR: begin
        o_val  = par_q;
        o_last = 1'b1;
        o_busy = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign o_ack = ack_q;
  assign o_src = src_q;

endmodule

// File: tb/tb_serial_sched.sv
// Bench for serial_sched: transaction-level model (bit list per word,
// round-robin pick by search) compared every cycle, plus directed literals.
module tb_serial_sched;
  localparam int W = 8;
  localparam int P = 4;
`ifdef SERIAL_SCHED_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic [P-1:0]   i_req = '0;
  logic [P*W-1:0] i_data = '0;
  logic           i_stp = 1'b0;
  logic [P-1:0]   o_ack;
  logic           o_val, o_sof, o_last, o_busy;
  logic [1:0]     o_src;

  serial_sched #(.p_width(W), .p_ports(P)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data), .i_stp(i_stp),
    .o_ack(o_ack), .o_val(o_val), .o_sof(o_sof), .o_last(o_last),
    .o_busy(o_busy), .o_src(o_src)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0, n_tot = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: a word is a list of bits walked by a position index.
  bit         m_busy = 0;
  bit         m_bits [NB];
  int         m_pos = 0, m_ptr = 0, m_src = 0;
  logic [P-1:0] m_ack = '0;

  function automatic int rr_pick(input logic [P-1:0] req, input int ptr);
    for (int i = 0; i < P; i++)
      if (req[(ptr + i) % P]) return (ptr + i) % P;
    return -1;
  endfunction

  always @(posedge i_clk) begin
    int g;
    logic [W-1:0] w;
    m_ack = '0;
    if (i_rst) begin
      m_busy = 0; m_ptr = 0; m_src = 0; m_pos = 0;
    end else if (m_busy) begin
      if (i_stp) begin
        m_pos++;
        if (m_pos == NB) m_busy = 0;
      end
    end else if (i_req != '0) begin
      g = rr_pick(i_req, m_ptr);
      w = i_data[g*W +: W];
      for (int b = 0; b < W; b++) m_bits[b] = w[b];
`ifdef SERIAL_SCHED_PARITY_EN
      m_bits[W] = ^w;
`endif
      m_pos = 0; m_busy = 1; m_src = g;
      m_ptr = (g + 1) % P;
      m_ack[g] = 1'b1;
    end
  end

  // Compare process: all outputs against the model every cycle.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("m_busy", o_busy, m_busy);
      check("m_val",  o_val,  m_busy ? m_bits[m_pos] : 1'b0);
      check("m_sof",  o_sof,  m_busy && m_pos == 0);
      check("m_last", o_last, m_busy && m_pos == NB - 1);
      check("m_ack",  o_ack,  m_ack);
      check("m_src",  o_src,  m_src);
    end
  end

  // Directed single word from port 0 with continuous strobe.
  task automatic single(input logic [7:0] d, input logic par_exp);
    i_req = '0; i_rst = 1'b1; i_stp = 1'b1;
    @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_val", o_val, 0);
    check("rst_ack", o_ack, 0);
    check("rst_src", o_src, 0);
    i_rst = 1'b0; i_req = 4'b0001; i_data = {24'h0, d};
    for (int i = 0; i < W; i++) begin
      @(negedge i_clk);
      check("s_bit", o_val, d[i]);
      check("s_sof", o_sof, i == 0);
      check("s_last", o_last, i == NB - 1);
      check("s_ack", o_ack, (i == 0) ? 4'b0001 : 4'b0000);
      i_req = '0;
    end
`ifdef SERIAL_SCHED_PARITY_EN
    @(negedge i_clk);
    check("s_par", o_val, par_exp);
    check("s_par_last", o_last, 1);
    check("s_par_busy", o_busy, 1);
`else
    if (par_exp) ;
`endif
    @(negedge i_clk);
    check("s_done", o_busy, 0);
  endtask

  logic [P-1:0] pend = '0;
  logic [W-1:0] word [P];

  initial begin
    int k;
    repeat (2) @(negedge i_clk);
    chk_en = 1'b1;

    // single word: A5 -> 1,0,1,0,0,1,0,1 ; parity literals 07 -> 1, 03 -> 0
    single(8'hA5, 1'b0);
`ifdef SERIAL_SCHED_PARITY_EN
    single(8'h07, 1'b1);
    single(8'h03, 1'b0);
`endif

    // round-robin with all ports requesting
    i_rst = 1'b1; i_req = 4'hF; i_data = 32'h44332211; i_stp = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    k = 0;
    for (int c = 0; c < 100 && k < 5; c++) begin
      @(negedge i_clk);
      if (o_sof) begin
        check("rr_src", o_src, k % 4);
        check("rr_ack", o_ack, 32'd1 << (k % 4));
        k++;
      end
    end
    if (k < 5) check("rr_timeout", k, 5);

    // reset mid-word from port 2, then search restarts at port 0
    i_rst = 1'b1; i_req = 4'b0100; i_data = 32'h00AA0000;
    @(negedge i_clk);
    i_rst = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && !o_sof; c++) @(negedge i_clk);
    check("mid_src2", o_src, 2);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("mid_busy", o_busy, 0);
    check("mid_val", o_val, 0);
    check("mid_src0", o_src, 0);
    i_rst = 1'b0; i_req = 4'b0101;
    @(negedge i_clk);
    check("mid_regrant", o_src, 0);
    check("mid_sof", o_sof, 1);
    i_req = '0;
    for (int c = 0; c < 30 && o_busy; c++) @(negedge i_clk);

    // randomized traffic: requesters hold data until acked
    for (int c = 0; c < 3000; c++) begin
      @(posedge i_clk);
      #1;
      for (int p = 0; p < P; p++) begin
        if (m_ack[p]) begin
          if ($urandom % 2 == 0) pend[p] = 1'b0;
          else word[p] = W'($urandom);
        end else if (!pend[p] && $urandom % 4 == 0) begin
          pend[p] = 1'b1;
          word[p] = W'($urandom);
        end
        i_data[p*W +: W] = word[p];
      end
      i_req = pend;
      i_stp = ($urandom % 3) != 0;
      i_rst = ($urandom % 150) == 0;
    end

    @(negedge i_clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
